// File: rtl/uart_rx.sv
// UART receiver: start + DATA_WIDTH data bits (LSB first) + even parity + stop, sampled on a 16x tick.
// Latency: rx_valid rises 1 clk after the baud tick at mid stop bit.
// Backpressure: single-entry holding register; a frame completing while it is full is dropped and flagged by overrun_err.
//
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   baud_x16_en       1-cycle oversample strobe, OVERSAMPLE per bit period
//   rx                asynchronous serial input, idle high
//   rx_ready          consumer handshake
//   rx_data/rx_valid  holding register contents and full flag
//   parity_err        qualifies rx_data: parity mismatch
//   frame_err         qualifies rx_data: stop bit sampled low
//   overrun_err       1-cycle pulse when a completed frame is dropped
//   rx_busy           receiver is inside a frame
module uart_rx #(
    parameter int DATA_WIDTH  = 8,
    parameter int OVERSAMPLE  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  baud_x16_en,
    input  logic                  rx,
    input  logic                  rx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  parity_err,
    output logic                  frame_err,
    output logic                  overrun_err,
    output logic                  rx_busy
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_WIDTH) + 1;

    localparam logic [TW-1:0] TICK_MID = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_END = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t                  state_q, state_d;
    logic [TW-1:0]           tick_cnt_q, tick_cnt_d;
    logic [BW-1:0]           bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0]   shift_q, shift_d;
    logic                    par_bit_q, par_bit_d;
    logic                    armed_q, armed_d;
    logic [SYNC_STAGES-1:0]  sync_q;

    logic [DATA_WIDTH-1:0]   rx_data_q, rx_data_d;
    logic                    rx_valid_q, rx_valid_d;
    logic                    parity_err_q, parity_err_d;
    logic                    frame_err_q, frame_err_d;
    logic                    overrun_q, overrun_d;

    logic                    rx_s;
    logic                    commit;

    assign rx_s = sync_q[SYNC_STAGES-1];

    // Receive FSM; only moves on oversample ticks.
    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        par_bit_d  = par_bit_q;
        armed_d    = armed_q;
        commit     = 1'b0;

        if (baud_x16_en) begin
            case (state_q)
                IDLE: begin
                    // A falling edge only counts once the line has been seen high,
                    // so a held break does not retrigger frames.
                    if (rx_s) begin
                        armed_d = 1'b1;
                    end else if (armed_q) begin
                        state_d    = START;
                        tick_cnt_d = '0;
                    end
                end
                START: begin
                    if (tick_cnt_q == TICK_MID) begin
                        if (rx_s) begin
                            // Glitch shorter than half a bit: false start.
                            state_d = IDLE;
                        end else begin
                            state_d    = DATA;
                            tick_cnt_d = '0;
                            bit_cnt_d  = '0;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + TW'(1);
                    end
                end
                DATA: begin
                    if (tick_cnt_q == TICK_END) begin
                        shift_d    = {rx_s, shift_q[DATA_WIDTH-1:1]};
                        bit_cnt_d  = bit_cnt_q + BW'(1);
                        tick_cnt_d = '0;
                        if (bit_cnt_q == BIT_LAST) begin
                            state_d = PARITY;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + TW'(1);
                    end
                end
                PARITY: begin
                    if (tick_cnt_q == TICK_END) begin
                        par_bit_d  = rx_s;
                        tick_cnt_d = '0;
                        state_d    = STOP;
                    end else begin
                        tick_cnt_d = tick_cnt_q + TW'(1);
                    end
                end
                STOP: begin
                    if (tick_cnt_q == TICK_END) begin
                        // Commit at mid stop bit leaves half a bit of slack for
                        // a back-to-back start edge.
                        commit     = 1'b1;
                        state_d    = IDLE;
                        armed_d    = rx_s;
                        tick_cnt_d = '0;
                    end else begin
                        tick_cnt_d = tick_cnt_q + TW'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Holding register and handshake; evaluated every clk.
    always_comb begin
        rx_data_d    = rx_data_q;
        rx_valid_d   = rx_valid_q;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;
        overrun_d    = 1'b0;

        if (commit) begin
            if (!rx_valid_q || rx_ready) begin
                rx_data_d    = shift_q;
                parity_err_d = (^shift_q) ^ par_bit_q;
                frame_err_d  = ~rx_s;
                rx_valid_d   = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            tick_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            par_bit_q    <= 1'b0;
            armed_q      <= 1'b0;
            sync_q       <= '1;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            tick_cnt_q   <= tick_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            par_bit_q    <= par_bit_d;
            armed_q      <= armed_d;
            sync_q       <= {sync_q[SYNC_STAGES-2:0], rx};
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
        end
    end

    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign parity_err  = parity_err_q;
    assign frame_err   = frame_err_q;
    assign overrun_err = overrun_q;
    assign rx_busy     = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: clean frames, parity/framing errors, false start, overrun, mid-frame reset.
// Latency: baud tick every 4 clk, so one bit is 64 clk; outputs sampled on the falling edge.
// Backpressure: rx_ready driven by the stimulus to exercise the holding register and overrun.
module tb_uart_rx;

    localparam int BIT_CLKS = 64;

    logic       clk;
    logic       rst;
    logic       baud_x16_en;
    logic       rx;
    logic       rx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       parity_err;
    logic       frame_err;
    logic       overrun_err;
    logic       rx_busy;

    int checks = 0;
    int errors = 0;

    // Monitor state
    int         valid_cyc = 0;
    int         ovr_cnt   = 0;
    int         hs_cnt    = 0;
    logic [7:0] hs_data   = 8'h00;
    logic       hs_perr   = 1'b0;
    logic       hs_ferr   = 1'b0;

    int hs0, ovr0, vc0;

    uart_rx #(
        .DATA_WIDTH (8),
        .OVERSAMPLE (16),
        .SYNC_STAGES(2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .baud_x16_en(baud_x16_en),
        .rx         (rx),
        .rx_ready   (rx_ready),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .overrun_err(overrun_err),
        .rx_busy    (rx_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Oversample strobe: one clk high out of every four.
    initial begin
        baud_x16_en = 1'b0;
        forever begin
            repeat (3) @(negedge clk);
            baud_x16_en = 1'b1;
            @(negedge clk);
            baud_x16_en = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (rx_valid) valid_cyc++;
        if (overrun_err) ovr_cnt++;
        if (rx_valid && rx_ready) begin
            hs_cnt++;
            hs_data = rx_data;
            hs_perr = parity_err;
            hs_ferr = frame_err;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic hold_bit(input logic v);
        rx = v;
        repeat (BIT_CLKS) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
        hold_bit(1'b0);
        for (int i = 0; i < 8; i++) hold_bit(d[i]);
        hold_bit(par);
        hold_bit(stop);
        rx = 1'b1;
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic snap;
        hs0  = hs_cnt;
        ovr0 = ovr_cnt;
        vc0  = valid_cyc;
    endtask

    initial begin
        rst      = 1'b1;
        rx       = 1'b1;
        rx_ready = 1'b1;
        repeat (4) @(negedge clk);

        // Reset state
        chk("rst_valid",   {31'd0, rx_valid},    32'd0);
        chk("rst_data",    {24'd0, rx_data},     32'd0);
        chk("rst_perr",    {31'd0, parity_err},  32'd0);
        chk("rst_ferr",    {31'd0, frame_err},   32'd0);
        chk("rst_ovr",     {31'd0, overrun_err}, 32'd0);
        chk("rst_busy",    {31'd0, rx_busy},     32'd0);
        rst = 1'b0;
        idle(40);

        // 1: clean 0xA5, even parity 0
        snap();
        send_frame(8'hA5, 1'b0, 1'b1);
        idle(20);
        chk("t1_hs",     hs_cnt - hs0,       32'd1);
        chk("t1_vcyc",   valid_cyc - vc0,    32'd1);
        chk("t1_data",   {24'd0, hs_data},   32'h0000_00A5);
        chk("t1_perr",   {31'd0, hs_perr},   32'd0);
        chk("t1_ferr",   {31'd0, hs_ferr},   32'd0);
        chk("t1_ovr",    ovr_cnt - ovr0,     32'd0);
        chk("t1_valid",  {31'd0, rx_valid},  32'd0);

        // 2: 0x01 with wrong parity bit
        snap();
        send_frame(8'h01, 1'b0, 1'b1);
        idle(20);
        chk("t2_hs",     hs_cnt - hs0,       32'd1);
        chk("t2_data",   {24'd0, hs_data},   32'h0000_0001);
        chk("t2_perr",   {31'd0, hs_perr},   32'd1);
        chk("t2_ferr",   {31'd0, hs_ferr},   32'd0);

        // 3: 0x3C with stop bit low, then a clean 0x55
        snap();
        send_frame(8'h3C, 1'b0, 1'b0);
        idle(20);
        chk("t3_hs",     hs_cnt - hs0,       32'd1);
        chk("t3_data",   {24'd0, hs_data},   32'h0000_003C);
        chk("t3_ferr",   {31'd0, hs_ferr},   32'd1);
        chk("t3_perr",   {31'd0, hs_perr},   32'd0);
        idle(80);
        snap();
        send_frame(8'h55, 1'b0, 1'b1);
        idle(20);
        chk("t3b_hs",    hs_cnt - hs0,       32'd1);
        chk("t3b_data",  {24'd0, hs_data},   32'h0000_0055);
        chk("t3b_ferr",  {31'd0, hs_ferr},   32'd0);
        chk("t3b_perr",  {31'd0, hs_perr},   32'd0);

        // 4: 4-tick glitch low is a false start
        snap();
        rx = 1'b0;
        repeat (16) @(negedge clk);
        rx = 1'b1;
        chk("t4_busy_on",  {31'd0, rx_busy}, 32'd1);
        idle(80);
        chk("t4_busy_off", {31'd0, rx_busy}, 32'd0);
        chk("t4_hs",       hs_cnt - hs0,     32'd0);
        chk("t4_vcyc",     valid_cyc - vc0,  32'd0);

        // 5: overrun with consumer stalled
        rx_ready = 1'b0;
        snap();
        send_frame(8'h11, 1'b0, 1'b1);
        send_frame(8'h22, 1'b0, 1'b1);
        idle(20);
        chk("t5_valid",  {31'd0, rx_valid},  32'd1);
        chk("t5_data",   {24'd0, rx_data},   32'h0000_0011);
        chk("t5_ovr",    ovr_cnt - ovr0,     32'd1);
        chk("t5_hs",     hs_cnt - hs0,       32'd0);
        rx_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("t5_clear",  {31'd0, rx_valid},  32'd0);
        chk("t5_hs2",    hs_cnt - hs0,       32'd1);
        chk("t5_hsdata", {24'd0, hs_data},   32'h0000_0011);
        idle(40);

        // 6: reset during data bit 3, then a clean 0x7E
        hold_bit(1'b0);
        hold_bit(1'b1);
        hold_bit(1'b0);
        hold_bit(1'b1);
        rx = 1'b0;
        repeat (20) @(negedge clk);
        chk("t6_busy_pre", {31'd0, rx_busy}, 32'd1);
        snap();
        rst = 1'b1;
        rx  = 1'b1;
        @(negedge clk);
        chk("t6_valid",  {31'd0, rx_valid},    32'd0);
        chk("t6_data",   {24'd0, rx_data},     32'd0);
        chk("t6_perr",   {31'd0, parity_err},  32'd0);
        chk("t6_ferr",   {31'd0, frame_err},   32'd0);
        chk("t6_ovr",    {31'd0, overrun_err}, 32'd0);
        chk("t6_busy",   {31'd0, rx_busy},     32'd0);
        @(negedge clk);
        rst = 1'b0;
        idle(200);
        chk("t6_nohs",   hs_cnt - hs0,       32'd0);
        send_frame(8'h7E, 1'b0, 1'b1);
        idle(20);
        chk("t6b_hs",    hs_cnt - hs0,       32'd1);
        chk("t6b_data",  {24'd0, hs_data},   32'h0000_007E);
        chk("t6b_perr",  {31'd0, hs_perr},   32'd0);
        chk("t6b_ferr",  {31'd0, hs_ferr},   32'd0);
        chk("t6b_ovr",   ovr_cnt - ovr0,     32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
